// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Drives a 4-bit combinational adder slice one nibble per clock, LS nibble
// first, to perform a 4*NIBBLES-bit add or subtract. The inter-nibble carry
// lives in carry_q. Subtraction is done as A + ~B + 1: B is inverted when
// latched and the initial carry is seeded with 1.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; result/flags hold the last completion
// S_RUN  | presenting nibble cnt to the slice, capturing its sum/carry
// S_DONE | one-cycle done pulse; start here begins the next operation

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic [CW+1:0]   bit_lo;

  logic            accept;
  logic            step;
  logic            last;
  logic [W-1:0]    sum_fin;
  logic            ovf_fin;

  // Bit offset of the nibble currently being presented.
  assign bit_lo = {cnt, 2'b00};

  // The final nibble is always the top one, so the completed sum is the
  // slice output spliced above the nibbles already captured.
  assign sum_fin = {add_sum, sum_q[W-5:0]};

  // Same-sign operands (B already inverted for subtract) whose sum flips sign.
  assign ovf_fin = (op_a_q[W-1] == op_b_q[W-1]) && (add_sum[3] != op_a_q[W-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and slice/handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        step    = 1'b1;
        add_a   = op_a_q[bit_lo +: 4];
        add_b   = op_b_q[bit_lo +: 4];
        add_cin = carry_q;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, working sum, inter-nibble carry and nibble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      op_a_q  <= op_a;
      op_b_q  <= sub ? ~op_b : op_b;
      sum_q   <= '0;
      carry_q <= sub;
      cnt     <= '0;
    end else if (step) begin
      sum_q[bit_lo +: 4] <= add_sum;
      carry_q            <= add_cout;
      cnt                <= last ? '0 : cnt + 1'b1;
    end
  end

  // Result and flags update only on the edge that captures the top nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (last) begin
      result    <= sum_fin;
      carry_out <= add_cout;
      overflow  <= ovf_fin;
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: behavioural 4-bit slice, scoreboard of expected
// results checked on each done pulse, plus per-nibble slice-pin checks.

module tb_adder_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  adder_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // Combinational 4-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         e;
    logic [W:0]   full;
    if (s) full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else   full = {1'b0, a} + {1'b0, b};
    e.r = full[W-1:0];
    e.c = full[W];
    if (s) e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    else   e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction

  // Carry into nibble k of a + bb + s.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] bb,
                                  input logic s, input int k);
    logic [W:0] mask;
    logic [W:0] part;
    if (k == 0) return s;
    mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
    part = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {{W{1'b0}}, s};
    return part[4 * k];
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result",    32'(result),    32'(e.r));
        chk("carry_out", 32'(carry_out), 32'(e.c));
        chk("overflow",  32'(overflow),  32'(e.v));
      end
    end
  end

  // One operation from IDLE/DONE: checks latency, busy length and slice pins.
  // inject pulses start (with junk operands) one cycle into RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit inject);
    logic [W-1:0] bb;
    int edges;
    int busy_cnt;
    int k;
    bit got;
    bb = s ? ~b : b;
    sbq.push_back(model(a, b, s));
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    edges = 1; busy_cnt = 0; k = 0; got = 0;
    while (!got && edges <= 20) begin
      if (busy) begin
        chk("add_a",   32'(add_a),   32'(a[4*k +: 4]));
        chk("add_b",   32'(add_b),   32'(bb[4*k +: 4]));
        chk("add_cin", 32'(add_cin), 32'(cin_at(a, bb, s, k)));
        busy_cnt++;
        k++;
      end
      if (inject && edges == 1) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      end else if (inject && edges == 2) begin
        start = 1'b0;
      end
      if (done) begin
        got = 1;
      end else begin
        @(posedge clk); #1;
        edges++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency",   32'(edges), 32'(NIB + 1));
    chk("busy_len",  32'(busy_cnt), 32'(NIB));
    chk("done_busy", 32'(busy), 32'd0);
    chk("idle_add_a",   32'(add_a), 32'd0);
    chk("idle_add_cin", 32'(add_cin), 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int edges;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    #8;
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_result",  32'(result),    32'd0);
    chk("rst_cout",    32'(carry_out), 32'd0);
    chk("rst_ovf",     32'(overflow),  32'd0);
    chk("rst_add_a",   32'(add_a),     32'd0);
    chk("rst_add_b",   32'(add_b),     32'd0);
    chk("rst_add_cin", 32'(add_cin),   32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    @(posedge clk); #1;

    // start during RUN is ignored.
    run_op(16'hA5A5, 16'h1111, 1'b0, 1'b1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_second_done", 32'(done), 32'd0);
    end

    // start held through DONE: two operations back to back.
    sbq.push_back(model(16'h1111, 16'h2222, 1'b0));
    sbq.push_back(model(16'h9000, 16'h1000, 1'b1));
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0;
    @(posedge clk); #1;
    op_a = 16'h9000; op_b = 16'h1000; sub = 1'b1;
    edges = 1; d1 = -1; d2 = -1;
    while (d2 < 0 && edges <= 30) begin
      if (done && d1 < 0) d1 = edges;
      else if (done) d2 = edges;
      if (d1 >= 0 && busy) start = 1'b0;
      if (d2 < 0) begin
        @(posedge clk); #1;
        edges++;
      end
    end
    start = 1'b0;
    chk("b2b_first",   32'(d1), 32'(NIB + 1));
    chk("b2b_spacing", 32'(d2 - d1), 32'(NIB + 1));

    // Reset after nibble 1 is captured aborts the operation.
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'h3333; op_b = 16'h4444; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",    32'(busy),      32'd0);
    chk("abort_done",    32'(done),      32'd0);
    chk("abort_add_a",   32'(add_a),     32'd0);
    chk("abort_add_b",   32'(add_b),     32'd0);
    chk("abort_add_cin", 32'(add_cin),   32'd0);
    chk("abort_result",  32'(result),    32'd0);
    chk("abort_cout",    32'(carry_out), 32'd0);
    chk("abort_ovf",     32'(overflow),  32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(done), 32'd0);
    end

    // Random mix.
    for (int i = 0; i < 10; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
